// File: rtl/router_fifo_sync_ctrl.sv
// Router FIFO sync controller: latches the header address, steers writes to one of
// three output FIFOs, and flushes any channel whose valid data sits unread too long.
module router_fifo_sync_ctrl #(
  parameter int unsigned TIMEOUT = 30  // legal range 2..31
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2,
  output logic       addr_err
);

  localparam logic [4:0] LAST_CNT = 5'(TIMEOUT - 1);

  logic [1:0] addr;
  logic [2:0] vld;
  logic [2:0] rd;
  logic [2:0] soft_reset;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr     <= 2'b00;
      addr_err <= 1'b0;
    end else if (detect_add) begin
      addr     <= data_in;
      addr_err <= (data_in == 2'b11);
    end
  end

  // Address 2'b11 selects nothing: the packet is dropped and no full flag is reported.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    write_enb = 3'b000;
    fifo_full = 1'b0;
    case (addr)
      2'b00: begin
        write_enb[0] = write_enb_reg;
        fifo_full    = full_0;
      end
      2'b01: begin
        write_enb[1] = write_enb_reg;
        fifo_full    = full_1;
      end
      2'b10: begin
        write_enb[2] = write_enb_reg;
        fifo_full    = full_2;
      end
      default: ;
    endcase
  end

  assign vld = {~empty_2, ~empty_1, ~empty_0};
  assign rd  = {read_enb_2, read_enb_1, read_enb_0};

  for (genvar n = 0; n < 3; n++) begin : g_ch
    logic       idle;
    logic [4:0] cnt;
    logic       sr_q;

    assign idle = vld[n] & ~rd[n];

    // The pulse cycle itself never counts, so pulses are at least TIMEOUT+1 apart.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt  <= 5'd0;
        sr_q <= 1'b0;
      end else if (!idle || sr_q) begin
        cnt  <= 5'd0;
        sr_q <= 1'b0;
      end else if (cnt == LAST_CNT) begin
        cnt  <= 5'd0;
        sr_q <= 1'b1;
      end else begin
        cnt  <= cnt + 5'd1;
        sr_q <= 1'b0;
      end
    end

    assign soft_reset[n] = sr_q;
  end

  assign vld_out_0    = vld[0];
  assign vld_out_1    = vld[1];
  assign vld_out_2    = vld[2];
  assign soft_reset_0 = soft_reset[0];
  assign soft_reset_1 = soft_reset[1];
  assign soft_reset_2 = soft_reset[2];

endmodule

// File: tb/tb_router_fifo_sync_ctrl.sv
// Directed testbench for router_fifo_sync_ctrl: address steering, drop on 2'b11,
// per-channel timeout pulses, simultaneous channels and mid-count reset.
module tb_router_fifo_sync_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       addr_err;

  int n_checks = 0;
  int n_fail   = 0;

  router_fifo_sync_ctrl #(.TIMEOUT(30)) dut (
    .clock(clock), .reset(reset), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
    .full_0(full_0), .full_1(full_1), .full_2(full_2),
    .write_enb(write_enb), .fifo_full(fifo_full),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .addr_err(addr_err)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_all();
    detect_add = 0; data_in = 2'b00; write_enb_reg = 0;
    read_enb_0 = 0; read_enb_1 = 0; read_enb_2 = 0;
    empty_0 = 1; empty_1 = 1; empty_2 = 1;
    full_0 = 0; full_1 = 0; full_2 = 0;
  endtask

  task automatic test_reset();
    idle_all();
    reset = 1;
    full_0 = 1;
    #2;
    n_checks++; if (write_enb !== 3'b000) begin n_fail++; $display("FAIL reset_write_enb got %b exp 000", write_enb); end
    n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL reset_fifo_full got %b exp 1", fifo_full); end
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err got %b exp 0", addr_err); end
    n_checks++; if ({soft_reset_2, soft_reset_1, soft_reset_0} !== 3'b000) begin
      n_fail++; $display("FAIL reset_soft_reset got %b exp 000", {soft_reset_2, soft_reset_1, soft_reset_0}); end
    tick();
    reset = 0;
    full_0 = 0;
    empty_1 = 0;
    #1;
    n_checks++; if ({vld_out_2, vld_out_1, vld_out_0} !== 3'b010) begin
      n_fail++; $display("FAIL vld_out got %b exp 010", {vld_out_2, vld_out_1, vld_out_0}); end
    empty_1 = 1;
  endtask

  task automatic test_steer();
    detect_add = 1; data_in = 2'b01;
    tick();
    detect_add = 0; write_enb_reg = 1; full_1 = 1; #1;
    n_checks++; if (write_enb !== 3'b010) begin n_fail++; $display("FAIL steer_we1 got %b exp 010", write_enb); end
    n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL steer_full1_hi got %b exp 1", fifo_full); end
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL steer_addr_err got %b exp 0", addr_err); end
    full_1 = 0; full_0 = 1; full_2 = 1; #1;
    n_checks++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL steer_full1_lo got %b exp 0", fifo_full); end
    // header in the same cycle as a write still uses the old address
    detect_add = 1; data_in = 2'b10; #1;
    n_checks++; if (write_enb !== 3'b010) begin n_fail++; $display("FAIL steer_old_addr got %b exp 010", write_enb); end
    tick();
    detect_add = 0; #1;
    n_checks++; if (write_enb !== 3'b100) begin n_fail++; $display("FAIL steer_we2 got %b exp 100", write_enb); end
    n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL steer_full2 got %b exp 1", fifo_full); end
    write_enb_reg = 0; #1;
    n_checks++; if (write_enb !== 3'b000) begin n_fail++; $display("FAIL steer_no_req got %b exp 000", write_enb); end
    full_0 = 0; full_2 = 0;
  endtask

  task automatic test_addr_err();
    detect_add = 1; data_in = 2'b11;
    tick();
    detect_add = 0; write_enb_reg = 1; full_0 = 1; full_1 = 1; full_2 = 1; #1;
    n_checks++; if (write_enb !== 3'b000) begin n_fail++; $display("FAIL err_we got %b exp 000", write_enb); end
    n_checks++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL err_full got %b exp 0", fifo_full); end
    n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL err_flag got %b exp 1", addr_err); end
    tick();
    n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL err_hold got %b exp 1", addr_err); end
    full_0 = 0; full_1 = 0; full_2 = 0;
    detect_add = 1; data_in = 2'b10;
    tick();
    detect_add = 0; #1;
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", addr_err); end
    n_checks++; if (write_enb !== 3'b100) begin n_fail++; $display("FAIL err_next_we got %b exp 100", write_enb); end
    write_enb_reg = 0;
  endtask

  // Channel 2 idle from edge 1: pulses after edges 30 and 61 (pulse cycle does not count).
  task automatic test_timeout();
    idle_all(); tick(); tick();
    empty_2 = 0;
    for (int i = 1; i <= 63; i++) begin
      tick();
      n_checks++;
      if (soft_reset_2 !== ((i == 30) || (i == 61))) begin
        n_fail++; $display("FAIL timeout_sr2 edge %0d got %b exp %b", i, soft_reset_2, (i == 30) || (i == 61));
      end
    end
  endtask

  // Read at edge 29 restarts the count: pulse after edge 59 only.
  task automatic test_read_restart();
    idle_all(); tick(); tick();
    empty_2 = 0;
    for (int i = 1; i <= 62; i++) begin
      read_enb_2 = (i == 29);
      tick();
      n_checks++;
      if (soft_reset_2 !== (i == 59)) begin
        n_fail++; $display("FAIL restart_sr2 edge %0d got %b exp %b", i, soft_reset_2, i == 59);
      end
    end
    read_enb_2 = 0;
  endtask

  task automatic test_back_to_back();
    idle_all(); tick(); tick();
    empty_0 = 0; empty_1 = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      n_checks++;
      if ({soft_reset_2, soft_reset_1, soft_reset_0} !== ((i == 30) ? 3'b011 : 3'b000)) begin
        n_fail++; $display("FAIL multi_sr edge %0d got %b exp %b", i,
                           {soft_reset_2, soft_reset_1, soft_reset_0}, (i == 30) ? 3'b011 : 3'b000);
      end
    end
  endtask

  task automatic test_mid_reset();
    idle_all(); tick(); tick();
    empty_0 = 0;
    for (int i = 1; i <= 15; i++) tick();
    reset = 1; #1;
    n_checks++; if (soft_reset_0 !== 1'b0) begin n_fail++; $display("FAIL midrst_sr0 got %b exp 0", soft_reset_0); end
    tick();
    reset = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      n_checks++;
      if (soft_reset_0 !== (i == 30)) begin
        n_fail++; $display("FAIL midrst_after edge %0d got %b exp %b", i, soft_reset_0, i == 30);
      end
    end
  endtask

  initial begin
    test_reset();
    test_steer();
    test_addr_err();
    test_timeout();
    test_read_restart();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_fifo_sync_ctrl.md
# router_fifo_sync_ctrl

Controller between the router's input FSM and its three output FIFOs (channels 0–2). It latches the destination address from each packet header and steers the write strobe to the selected FIFO. It returns that FIFO's full flag to the FSM, publishes per-channel valid-out, and issues a one-cycle soft reset to any channel whose valid data sits unread for TIMEOUT cycles.

## Interface
- TIMEOUT, 30, idle-read cycles before a channel is soft-reset; legal range 2..31.

- clock  in  1  rising-edge system clock
- reset  in  1  asynchronous, active-high; clears all state
- detect_add  in  1  header byte on data_in this cycle; latch address
- data_in  in  2  destination address (header bits [1:0])
- write_enb_reg  in  1  FSM request to write current byte into selected FIFO
- read_enb_0/1/2  in  1 each  downstream read strobe per channel
- empty_0/1/2  in  1 each  FIFO empty flags
- full_0/1/2  in  1 each  FIFO full flags
- write_enb  out  3  one-hot FIFO write enables (bit n = channel n)
- fifo_full  out  1  full flag of currently selected channel
- vld_out_0/1/2  out  1 each  channel has data
- soft_reset_0/1/2  out  1 each  registered one-cycle FIFO flush pulse
- addr_err  out  1  last latched address was 2'b11

## Operation
- Address register addr[1:0]: on clock edge with detect_add=1, addr <= data_in. Reset value 2'b00. Holds otherwise.
- addr_err: on detect_add edge, set to (data_in==2'b11), else hold. Reset 0.
- write_enb (combinational from registered addr): write_enb_reg ? onehot(addr) : 3'b000. Address 2'b11 yields 3'b000, so the packet is dropped. A write in the same cycle as detect_add uses the old addr.
- fifo_full (combinational): full_0/1/2 selected by addr; 0 when addr==2'b11.
- vld_out_n = ~empty_n (combinational).
- Per-channel timeout counter cnt_n, 5 bits, reset 0:
  - channel idle in a cycle when vld_out_n=1 and read_enb_n=0.
  - not idle, or soft_reset_n=1 in this cycle -> cnt_n <= 0.
  - idle and cnt_n < TIMEOUT-1 -> cnt_n <= cnt_n+1.
  - idle and cnt_n == TIMEOUT-1 -> soft_reset_n <= 1, cnt_n <= 0.
  - soft_reset_n otherwise <= 0. It is never high two consecutive cycles.
- Channels are fully independent; several soft_resets may fire in the same cycle.
- No interaction between soft_reset and addr. The FSM restarts on the next header.

## Timing
- All outputs after reset: write_enb=000, fifo_full=full_0, vld_out_n=~empty_n, soft_reset_n=0, addr_err=0.
- write_enb, fifo_full and vld_out are zero-latency combinational paths.
- addr and addr_err are visible the cycle after the detect_add edge.
- Timeout: if the channel is idle at edges e1..eTIMEOUT (cnt 0..TIMEOUT-1), soft_reset_n is high for exactly the cycle after edge eTIMEOUT.
- Any read_enb_n=1 or vld_out_n=0 sample restarts the count from zero.
- Reset asserted mid-count clears cnt and soft_reset immediately (asynchronous). Counting resumes from 0 after release.
- read_enb_n is honoured even when vld_out_n=0. Counting is gated only by the idle condition.

## Test plan
- Reset, then detect_add=1 with data_in=2'b01; next cycle write_enb_reg=1 -> write_enb=3'b010 and fifo_full tracks full_1; addr_err=0.
- Header data_in=2'b11, then write_enb_reg=1 -> write_enb=000, fifo_full=0, addr_err=1. Next header 2'b10 -> addr_err=0, write_enb=3'b100.
- empty_2=0, read_enb_2=0 held, TIMEOUT=30 -> soft_reset_2 high exactly one cycle, after the 30th edge. Then, with empty_2 still 0, it fires again 30 cycles later.
- Same as previous, but pulse read_enb_2 at idle cycle 29 -> no soft_reset; the next pulse occurs 30 idle cycles after that read.
- Channels 0 and 1 go valid on the same cycle, both unread -> soft_reset_0 and soft_reset_1 fire in the same cycle; channel 2 is unaffected.
- Assert reset at idle cycle 15 of channel 0 -> cnt cleared, no soft_reset. After release, a full 30 idle cycles are needed before soft_reset_0 fires.
